// File: rtl/triangle_assembler_pkg.sv
// Shared types for triangle assembly: fixed-point vertices, triangles, cull modes and
// the wide signed-area arithmetic types.
package triangle_assembler_pkg;

  typedef logic signed [31:0] q16_16_t;

  typedef struct packed {
    q16_16_t x;
    q16_16_t y;
    q16_16_t z;
  } vec3_t;

  typedef struct packed {
    vec3_t       pos;
    logic [31:0] color;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef enum logic [1:0] {
    CULL_NONE  = 2'd0,
    CULL_BACK  = 2'd1,
    CULL_FRONT = 2'd2
  } cull_mode_e;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_AREA    = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  localparam int DIFF_W = 33;
  localparam int PROD_W = 66;
  localparam int AREA_W = 67;

  typedef logic signed [DIFF_W-1:0] diff_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [AREA_W-1:0] area_t;

  // Twice the signed screen-space area; positive for counter-clockwise winding.
  function automatic area_t signed_area2(input q16_16_t x0, input q16_16_t y0,
                                         input q16_16_t x1, input q16_16_t y1,
                                         input q16_16_t x2, input q16_16_t y2);
    diff_t dx1, dy1, dx2, dy2;
    prod_t p0, p1;
    dx1 = diff_t'(x1) - diff_t'(x0);
    dy1 = diff_t'(y1) - diff_t'(y0);
    dx2 = diff_t'(x2) - diff_t'(x0);
    dy2 = diff_t'(y2) - diff_t'(y0);
    p0  = prod_t'(dx1) * prod_t'(dy2);
    p1  = prod_t'(dx2) * prod_t'(dy1);
    return area_t'(p0) - area_t'(p1);
  endfunction

endpackage

// File: rtl/tri_area_pipe.sv
// Two-stage signed-area unit: products are registered on start, the full-width
// difference is formed combinationally in the following cycle while done is high.
module tri_area_pipe
  import triangle_assembler_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start,
  input  q16_16_t x0,
  input  q16_16_t y0,
  input  q16_16_t x1,
  input  q16_16_t y1,
  input  q16_16_t x2,
  input  q16_16_t y2,
  output logic    done,
  output area_t   area
);

  diff_t dx1, dy1, dx2, dy2;
  prod_t p0, p1;

  // 33-bit differences cannot overflow for any pair of 32-bit coordinates.
  always_comb begin
    dx1 = diff_t'(x1) - diff_t'(x0);
    dy1 = diff_t'(y1) - diff_t'(y0);
    dx2 = diff_t'(x2) - diff_t'(x0);
    dy2 = diff_t'(y2) - diff_t'(y0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0   <= '0;
      p1   <= '0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        p0 <= prod_t'(dx1) * prod_t'(dy2);
        p1 <= prod_t'(dx2) * prod_t'(dy1);
      end
    end
  end

  assign area = area_t'(p0) - area_t'(p1);

endmodule

// File: rtl/triangle_assembler.sv
// Groups every three accepted vertices into a triangle, culls by signed area and
// hands survivors downstream over a valid/ready handshake.
module triangle_assembler
  import triangle_assembler_pkg::*;
#(
  parameter cull_mode_e CULL_MODE       = CULL_BACK,
  parameter bit         DROP_DEGENERATE = 1'b1,
  parameter int         CNT_BITS        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  vertex_t             vertex,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                restart,
  output triangle_t           out_tri,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [CNT_BITS-1:0] tri_count,
  output logic [CNT_BITS-1:0] cull_count,
  output state_e              state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a source
  // holding valid keeps its payload unchanged until that edge.

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  vertex_t    slots [3];
  logic [1:0] idx;
  logic       area_start;
  logic       area_done;
  area_t      area;
  logic       area_zero;
  logic       area_neg;
  logic       cull;

  assign in_ready   = (state == ST_COLLECT) && !restart;
  assign busy       = (idx != 2'd0) || (state != ST_COLLECT);
  assign area_start = (state == ST_AREA);

  tri_area_pipe u_area (
    .clk   (clk),
    .rst_n (rst_n),
    .start (area_start),
    .x0    (slots[0].pos.x),
    .y0    (slots[0].pos.y),
    .x1    (slots[1].pos.x),
    .y1    (slots[1].pos.y),
    .x2    (slots[2].pos.x),
    .y2    (slots[2].pos.y),
    .done  (area_done),
    .area  (area)
  );

  always_comb begin
    area_zero = (area == '0);
    area_neg  = area[AREA_W-1];
    cull      = (DROP_DEGENERATE && area_zero)
             || ((CULL_MODE == CULL_BACK)  && area_neg)
             || ((CULL_MODE == CULL_FRONT) && !area_neg && !area_zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_COLLECT;
      idx        <= 2'd0;
      out_valid  <= 1'b0;
      out_tri    <= '0;
      tri_count  <= '0;
      cull_count <= '0;
      for (int i = 0; i < 3; i++) slots[i] <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          // restart wins over a vertex offered in the same cycle
          if (restart) begin
            idx <= 2'd0;
          end else if (in_valid) begin
            slots[idx] <= vertex;
            if (idx == 2'd2) begin
              idx   <= 2'd0;
              state <= ST_AREA;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        ST_AREA: state <= ST_DECIDE;
        ST_DECIDE: begin
          if (area_done) begin
            if (cull) begin
              if (cull_count != CNT_MAX) cull_count <= cull_count + CNT_BITS'(1);
              state <= ST_COLLECT;
            end else begin
              out_tri   <= '{v0: slots[0], v1: slots[1], v2: slots[2]};
              out_valid <= 1'b1;
              state     <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (tri_count != CNT_MAX) tri_count <= tri_count + CNT_BITS'(1);
            state <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: a default back-culling instance and a no-cull instance
// with 2-bit counters, driven by directed cases and random vertex streams.
`timescale 1ns/1ps
module tb_triangle_assembler;
  import triangle_assembler_pkg::*;

  localparam int TRI_W = $bits(triangle_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vertex_t    vtx       [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       restart   [2];
  triangle_t  out_tri   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       busy      [2];
  state_e     state     [2];
  logic [15:0] tri_count0, cull_count0;
  logic [1:0]  tri_count1, cull_count1;

  triangle_assembler dut0 (
    .clk(clk), .rst_n(rst_n), .vertex(vtx[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .restart(restart[0]), .out_tri(out_tri[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]),
    .tri_count(tri_count0), .cull_count(cull_count0), .state(state[0])
  );

  triangle_assembler #(.CULL_MODE(CULL_NONE), .DROP_DEGENERATE(1'b0), .CNT_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .vertex(vtx[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .restart(restart[1]), .out_tri(out_tri[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]),
    .tri_count(tri_count1), .cull_count(cull_count1), .state(state[1])
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [TRI_W-1:0] exp_q0[$];
  logic [TRI_W-1:0] exp_q1[$];
  vertex_t pend [2][3];
  int  pend_n   [2] = '{0, 0};
  int  exp_tri  [2] = '{0, 0};
  int  exp_cull [2] = '{0, 0};
  int  cull_mode_of [2] = '{1, 0};
  bit  drop_deg_of  [2] = '{1'b1, 1'b0};
  bit  rand_ready = 1'b0;
  vertex_t last_v = '0;

  task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_tri(input string name, input logic [TRI_W-1:0] got,
                         input logic [TRI_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: doubled signed area with plain wide integer arithmetic.
  function automatic bit model_cull(input vertex_t a, input vertex_t b, input vertex_t c,
                                    input int mode, input bit drop_deg);
    logic signed [127:0] ax, ay, bx, by, cx, cy, ar;
    ax = a.pos.x; ay = a.pos.y;
    bx = b.pos.x; by = b.pos.y;
    cx = c.pos.x; cy = c.pos.y;
    ar = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
    return (drop_deg && ar == 0) || (mode == 1 && ar < 0) || (mode == 2 && ar > 0);
  endfunction

  task automatic model_accept(input int d, input vertex_t v);
    pend[d][pend_n[d]] = v;
    pend_n[d]++;
    if (pend_n[d] == 3) begin
      pend_n[d] = 0;
      if (model_cull(pend[d][0], pend[d][1], pend[d][2], cull_mode_of[d], drop_deg_of[d]))
        exp_cull[d]++;
      else begin
        exp_tri[d]++;
        if (d == 0) exp_q0.push_back({pend[d][0], pend[d][1], pend[d][2]});
        else        exp_q1.push_back({pend[d][0], pend[d][1], pend[d][2]});
      end
    end
  endtask

  function automatic vertex_t mkv(input int xi, input int yi);
    vertex_t v;
    v.pos.x = xi * 65536;
    v.pos.y = yi * 65536;
    v.pos.z = $urandom;
    v.color = $urandom;
    return v;
  endfunction

  function automatic vertex_t rand_vertex();
    vertex_t v;
    case ($urandom_range(0, 3))
      0: begin v.pos.x = $urandom; v.pos.y = $urandom; v.pos.z = $urandom; v.color = $urandom; end
      3: begin v = last_v; v.color = $urandom; end
      default: v = mkv(int'($urandom_range(0, 100)) - 50, int'($urandom_range(0, 100)) - 50);
    endcase
    last_v = v;
    return v;
  endfunction

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send_vertex(input int d, input vertex_t v);
    bit done = 1'b0;
    int waited = 0;
    vtx[d] = v;
    in_valid[d] = 1'b1;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready[d]) done = 1'b1;
      waited++;
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    if (done) model_accept(d, v);
    else chk_val("accept_timeout", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic send_xy(input int d, input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
    send_vertex(d, mkv(x0, y0));
    send_vertex(d, mkv(x1, y1));
    send_vertex(d, mkv(x2, y2));
  endtask

  task automatic restart_cycle(input int d);
    restart[d] = 1'b1;
    in_valid[d] = 1'($urandom_range(0, 1));
    vtx[d] = rand_vertex();
    @(negedge clk);
    chk_val("restart_in_ready", 32'(in_ready[d]), 32'd0);
    @(posedge clk); #1;
    restart[d] = 1'b0;
    in_valid[d] = 1'b0;
    pend_n[d] = 0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[d] || (d == 0 ? exp_q0.size() : exp_q1.size()) != 0) && n < 500);
    if (n >= 500) chk_val("idle_timeout", 32'(busy[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_check(input string tag);
    #2 rst_n = 1'b0;
    in_valid = '{1'b0, 1'b0};
    out_ready[0] = 1'b0;
    #1;
    chk_val({tag, "_out_valid"}, 32'(out_valid[0]), 32'd0);
    chk_val({tag, "_busy"}, 32'(busy[0]), 32'd0);
    chk_val({tag, "_tri_count"}, 32'(tri_count0), 32'd0);
    chk_val({tag, "_cull_count"}, 32'(cull_count0), 32'd0);
    chk_tri({tag, "_out_tri"}, out_tri[0], '0);
    exp_q0.delete();
    exp_q1.delete();
    pend_n = '{0, 0};
    exp_tri = '{0, 0};
    exp_cull = '{0, 0};
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitors ----------------
  logic [TRI_W-1:0] held0;
  bit hold0 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) hold0 = 1'b0;
    else if (out_valid[0]) begin
      if (hold0) chk_tri("hold_stable", out_tri[0], held0);
      if (out_ready[0]) begin
        hold0 = 1'b0;
        if (exp_q0.size() == 0) chk_tri("unexpected_tri0", out_tri[0], 'x);
        else chk_tri("tri0", out_tri[0], exp_q0.pop_front());
      end else begin
        hold0 = 1'b1;
        held0 = out_tri[0];
      end
    end else if (hold0) begin
      chk_val("hold_dropped", 32'(out_valid[0]), 32'd1);
      hold0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid[1] && out_ready[1]) begin
      if (exp_q1.size() == 0) chk_tri("unexpected_tri1", out_tri[1], 'x);
      else chk_tri("tri1", out_tri[1], exp_q1.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready[0] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vtx = '{'0, '0};
    in_valid = '{1'b0, 1'b0};
    restart = '{1'b0, 1'b0};
    out_ready = '{1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk_val("rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk_val("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk_val("rst_busy", 32'(busy[0]), 32'd0);
    chk_val("rst_tri_count", 32'(tri_count0), 32'd0);
    chk_val("rst_cull_count", 32'(cull_count0), 32'd0);
    chk_tri("rst_out_tri", out_tri[0], '0);
    chk_val("rst_state", 32'(state[0]), 32'(ST_COLLECT));
    chk_val("rst_busy1", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;

    // CCW triangle, latency and back-pressure
    send_xy(0, 0, 0, 10, 0, 0, 10);
    @(negedge clk);
    chk_val("ccw_in_ready_n1", 32'(in_ready[0]), 32'd0);
    chk_val("ccw_valid_n1", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    chk_val("ccw_valid_n2", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    chk_val("ccw_valid_n3", 32'(out_valid[0]), 32'd1);
    vtx[0] = mkv(1, 1);
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_val("stall_in_ready", 32'(in_ready[0]), 32'd0);
      chk_val("stall_valid", 32'(out_valid[0]), 32'd1);
    end
    @(posedge clk); #1 out_ready[0] = 1'b1;
    @(negedge clk);
    chk_val("hs_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1 out_ready[0] = 1'b0;
    @(negedge clk);
    chk_val("ccw_tri_count", 32'(tri_count0), 32'd1);
    chk_val("post_hs_in_ready", 32'(in_ready[0]), 32'd1);
    chk_val("post_hs_busy", 32'(busy[0]), 32'd0);
    model_accept(0, vtx[0]);
    @(posedge clk); #1 in_valid[0] = 1'b0;
    @(negedge clk);
    chk_val("one_held_busy", 32'(busy[0]), 32'd1);
    @(posedge clk); #1;

    // restart with two vertices held
    send_vertex(0, mkv(3, 7));
    restart_cycle(0);
    @(negedge clk);
    chk_val("restart_busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send_xy(0, 0, 0, 20, 0, 0, 20);
    wait_idle(0);
    chk_val("restart_tri_count", 32'(tri_count0), 32'(exp_tri[0]));

    // CW triangle is back-facing
    send_xy(0, 0, 0, 0, 10, 10, 0);
    @(negedge clk);
    chk_val("cw_valid_n1", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    chk_val("cw_valid_n2", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    chk_val("cw_valid_n3", 32'(out_valid[0]), 32'd0);
    chk_val("cw_in_ready_n3", 32'(in_ready[0]), 32'd1);
    chk_val("cw_cull_count", 32'(cull_count0), 32'd1);
    @(posedge clk); #1;

    // collinear dropped, extremes emitted
    send_xy(0, 0, 0, 5, 5, 10, 10);
    wait_idle(0);
    chk_val("collinear_cull_count", 32'(cull_count0), 32'd2);
    send_xy(0, -32768, -32768, 32767, -32768, -32768, 32767);
    wait_idle(0);
    chk_val("extreme_tri_count", 32'(tri_count0), 32'd3);

    // no-cull instance: collinear and CW emitted, counter saturates at 3
    send_xy(1, 0, 0, 5, 5, 10, 10);
    send_xy(1, 0, 0, 0, 10, 10, 0);
    wait_idle(1);
    chk_val("nocull_tri_count2", 32'(tri_count1), 32'd2);
    send_xy(1, 0, 0, 10, 0, 0, 10);
    for (int i = 0; i < 6; i++) send_vertex(1, rand_vertex());
    wait_idle(1);
    chk_val("nocull_tri_sat", 32'(tri_count1), 32'(exp_tri[1] > 3 ? 3 : exp_tri[1]));
    chk_val("nocull_cull_count", 32'(cull_count1), 32'(exp_cull[1]));

    // reset while in AREA, then while in OUTPUT
    send_xy(0, 0, 0, 10, 0, 0, 10);
    chk_val("in_area_state", 32'(state[0]), 32'(ST_AREA));
    reset_check("rst_area");
    out_ready[0] = 1'b0;
    send_xy(0, 1, 1, 30, 2, 4, 25);
    tri_count0_seed: begin
      repeat (3) @(negedge clk);
      chk_val("in_output_valid", 32'(out_valid[0]), 32'd1);
    end
    reset_check("rst_output");

    // random stream with random back-pressure and restarts
    rand_ready = 1'b1;
    for (int t = 0; t < 450; t++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) restart_cycle(0);
      else if (r < 3) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else send_vertex(0, rand_vertex());
    end
    while (pend_n[0] != 0) send_vertex(0, rand_vertex());
    rand_ready = 1'b0;
    @(posedge clk); #2 out_ready[0] = 1'b1;
    wait_idle(0);
    chk_val("rand_tri_count", 32'(tri_count0), 32'(exp_tri[0]));
    chk_val("rand_cull_count", 32'(cull_count0), 32'(exp_cull[0]));
    chk_val("rand_queue_empty", 32'(exp_q0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
